// File: rtl/bp_table_ctrl.sv
// Branch-predictor pattern-history-table controller: init sweep, prediction reads,
// and a small FIFO of counter updates arbitrated onto a single-port table.
module bp_table_ctrl #(
    parameter int XLEN        = 32,
    parameter int PHT_ENTRIES = 64,
    parameter int QDEPTH      = 4,
    parameter int STARVE_MAX  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tbl_clear,
    input  logic                           pred_req,
    input  logic [XLEN-1:0]                pred_pc,
    output logic                           pred_grant,
    output logic                           pred_valid,
    output logic [1:0]                     pred_ctr,
    output logic                           pred_taken,
    input  logic                           upd_valid,
    input  logic [XLEN-1:0]                upd_pc,
    input  logic                           upd_taken,
    input  logic [1:0]                     upd_ctr_old,
    output logic                           upd_ready,
    output logic                           tbl_en,
    output logic                           tbl_we,
    output logic [$clog2(PHT_ENTRIES)-1:0] tbl_addr,
    output logic [1:0]                     tbl_wdata,
    input  logic [1:0]                     tbl_rdata,
    output logic                           init_done,
    output logic                           dbg_state
);

    localparam int IDX_W  = $clog2(PHT_ENTRIES);
    localparam int QPTR_W = $clog2(QDEPTH);
    localparam int QCNT_W = QPTR_W + 1;
    localparam int SC_W   = $clog2(STARVE_MAX + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PHT_ENTRIES - 1);
    localparam logic [QCNT_W-1:0] Q_FULL   = QCNT_W'(QDEPTH);
    localparam logic [SC_W-1:0]   SC_MAX   = SC_W'(STARVE_MAX);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                  state, next_state;
    logic [IDX_W-1:0]        sweep_idx;
    logic [IDX_W+1:0]        q_mem [QDEPTH];
    logic [QPTR_W-1:0]       wr_ptr, rd_ptr;
    logic [QCNT_W-1:0]       q_count;
    logic [SC_W-1:0]         starve_cnt;
    logic                    do_enq, do_deq;
    logic [1:0]              new_ctr;
    logic [IDX_W-1:0]        pred_idx, upd_idx, head_idx;
    logic [1:0]              head_ctr;
    logic                    q_empty;
    logic                    unused_pc_bits;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                              upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

    assign {head_idx, head_ctr} = q_mem[rd_ptr];
    assign q_empty = (q_count == '0);

    // Update channel: an update transfers on a rising edge where upd_valid && upd_ready
    // are both high; upd_ready never depends on upd_valid.
    assign upd_ready = (state == ST_RUN) && (q_count != Q_FULL);
    assign do_enq    = upd_valid && upd_ready;

    always_comb begin
        new_ctr = upd_ctr_old;
        if (upd_taken) begin
            if (upd_ctr_old != 2'b11) new_ctr = upd_ctr_old + 2'b01;
        end else begin
            if (upd_ctr_old != 2'b00) new_ctr = upd_ctr_old - 2'b01;
        end
    end

    // Table port arbitration; everything is held at zero while reset is asserted.
    always_comb begin
        next_state = state;
        tbl_en     = 1'b0;
        tbl_we     = 1'b0;
        tbl_addr   = '0;
        tbl_wdata  = 2'b00;
        pred_grant = 1'b0;
        do_deq     = 1'b0;
        if (reset) begin
            case (state)
                ST_INIT: begin
                    if (!tbl_clear) begin
                        tbl_en    = 1'b1;
                        tbl_we    = 1'b1;
                        tbl_addr  = sweep_idx;
                        tbl_wdata = 2'b01;
                        if (sweep_idx == IDX_LAST) next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tbl_clear) begin
                        next_state = ST_INIT;
                    end else if (!q_empty && (!pred_req || starve_cnt == SC_MAX)) begin
                        tbl_en    = 1'b1;
                        tbl_we    = 1'b1;
                        tbl_addr  = head_idx;
                        tbl_wdata = head_ctr;
                        do_deq    = 1'b1;
                    end else if (pred_req) begin
                        tbl_en     = 1'b1;
                        tbl_addr   = pred_idx;
                        pred_grant = 1'b1;
                    end
                end
                default: next_state = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_INIT;
            sweep_idx  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            starve_cnt <= '0;
            pred_valid <= 1'b0;
        end else begin
            state      <= next_state;
            pred_valid <= pred_grant;
            if (tbl_clear) begin
                sweep_idx  <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                q_count    <= '0;
                starve_cnt <= '0;
            end else begin
                // Wraps back to zero on the last entry, ready for the next sweep.
                if (state == ST_INIT) sweep_idx <= sweep_idx + 1'b1;
                if (do_enq) wr_ptr <= wr_ptr + 1'b1;
                if (do_deq) rd_ptr <= rd_ptr + 1'b1;
                case ({do_enq, do_deq})
                    2'b10:   q_count <= q_count + 1'b1;
                    2'b01:   q_count <= q_count - 1'b1;
                    default: q_count <= q_count;
                endcase
                if (do_deq || q_empty) starve_cnt <= '0;
                else if (pred_grant && starve_cnt != SC_MAX) starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) q_mem[wr_ptr] <= {upd_idx, new_ctr};
    end

    assign pred_ctr   = pred_valid ? tbl_rdata : 2'b00;
    assign pred_taken = pred_ctr[1];
    assign init_done  = (state == ST_RUN);
    assign dbg_state  = (state == ST_RUN);

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Bench for bp_table_ctrl: a table SRAM stand-in, a queue-based reference model,
// directed vectors, multi-cycle corner sequences and randomized traffic.
module tb_bp_table_ctrl;

    localparam int ENTRIES = 64;
    localparam int QDEPTH  = 4;
    localparam int SMAX    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        tbl_clear;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_grant;
    logic        pred_valid;
    logic [1:0]  pred_ctr;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [1:0]  upd_ctr_old;
    logic        upd_ready;
    logic        tbl_en;
    logic        tbl_we;
    logic [5:0]  tbl_addr;
    logic [1:0]  tbl_wdata;
    logic [1:0]  tbl_rdata;
    logic        init_done;
    logic        dbg_state;

    bp_table_ctrl #(.XLEN(32), .PHT_ENTRIES(ENTRIES), .QDEPTH(QDEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset), .tbl_clear(tbl_clear),
        .pred_req(pred_req), .pred_pc(pred_pc), .pred_grant(pred_grant),
        .pred_valid(pred_valid), .pred_ctr(pred_ctr), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_ctr_old(upd_ctr_old), .upd_ready(upd_ready),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .tbl_rdata(tbl_rdata), .init_done(init_done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- table SRAM stand-in ----------------
    logic [1:0] pht_mem [ENTRIES];
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) pht_mem[tbl_addr] <= tbl_wdata;
            else        tbl_rdata <= pht_mem[tbl_addr];
        end
    end

    // ---------------- reference model state ----------------
    logic [1:0] ref_pht [ENTRIES];
    logic [7:0] exp_q[$];          // {index, new counter} in arrival order
    bit         m_run;
    int         m_sweep;
    int         m_starve;
    bit         m_pv;
    logic [1:0] m_pv_ctr;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_sweep = 0; m_starve = 0; m_pv = 0; m_pv_ctr = 2'b00;
        exp_q.delete();
    endtask

    // Evaluate one cycle's expected outputs from the current inputs, compare,
    // then advance the model to the state after the coming rising edge.
    task automatic model_cycle();
        bit e_grant, e_en, e_we, e_ready, q_nonempty, next_pv;
        int e_addr, e_wdata, pidx, uidx, nctr;
        logic [1:0] next_ctr;
        logic [7:0] head;
        e_grant = 0; e_en = 0; e_we = 0; e_ready = 0; e_addr = 0; e_wdata = 0;
        next_pv = 0; next_ctr = 2'b00;
        pidx = (pred_pc / 4) % ENTRIES;
        uidx = (upd_pc / 4) % ENTRIES;
        if (upd_taken) nctr = (upd_ctr_old == 3) ? 3 : int'(upd_ctr_old) + 1;
        else           nctr = (upd_ctr_old == 0) ? 0 : int'(upd_ctr_old) - 1;

        chk("pred_valid", pred_valid, m_pv);
        chk("pred_ctr", pred_ctr, m_pv_ctr);
        chk("pred_taken", pred_taken, m_pv_ctr[1]);
        chk("init_done", init_done, m_run);
        chk("dbg_state", dbg_state, m_run);

        if (!m_run) begin
            if (tbl_clear) m_sweep = 0;
            else begin
                e_en = 1; e_we = 1; e_addr = m_sweep; e_wdata = 1;
                ref_pht[m_sweep] = 2'b01;
                m_sweep++;
                if (m_sweep == ENTRIES) begin m_run = 1; m_sweep = 0; end
            end
        end else begin
            e_ready = exp_q.size() < QDEPTH;
            q_nonempty = exp_q.size() > 0;
            if (tbl_clear) begin
                exp_q.delete(); m_starve = 0; m_run = 0; m_sweep = 0;
            end else begin
                if (q_nonempty && (!pred_req || m_starve == SMAX)) begin
                    head = exp_q.pop_front();
                    e_en = 1; e_we = 1; e_addr = int'(head[7:2]); e_wdata = int'(head[1:0]);
                    ref_pht[head[7:2]] = head[1:0];
                    m_starve = 0;
                end else if (pred_req) begin
                    e_grant = 1; e_en = 1; e_addr = pidx;
                    next_pv = 1; next_ctr = ref_pht[pidx];
                    if (q_nonempty) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
                    else            m_starve = 0;
                end
                if (upd_valid && e_ready) exp_q.push_back({6'(uidx), 2'(nctr)});
            end
        end

        chk("pred_grant", pred_grant, e_grant);
        chk("tbl_en", tbl_en, e_en);
        chk("tbl_we", tbl_we, e_we);
        chk("upd_ready", upd_ready, e_ready);
        if (e_en) chk("tbl_addr", tbl_addr, e_addr);
        if (e_we) chk("tbl_wdata", tbl_wdata, e_wdata);
        m_pv = next_pv;
        m_pv_ctr = next_ctr;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic req, input logic [31:0] pc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [1:0] uold,
                         input logic clr);
        @(negedge clk);
        pred_req = req; pred_pc = pc; upd_valid = uv; upd_pc = upc;
        upd_taken = ut; upd_ctr_old = uold; tbl_clear = clr;
        #1;
        model_cycle();
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, pred_grant, 0);
        chk({tag, "_pvalid"}, pred_valid, 0);
        chk({tag, "_pctr"}, pred_ctr, 0);
        chk({tag, "_ptaken"}, pred_taken, 0);
        chk({tag, "_ready"}, upd_ready, 0);
        chk({tag, "_en"}, tbl_en, 0);
        chk({tag, "_we"}, tbl_we, 0);
        chk({tag, "_addr"}, tbl_addr, 0);
        chk({tag, "_wdata"}, tbl_wdata, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // Asserts reset between edges, checks outputs drop at once, releases after an edge.
    task automatic reset_pulse(input string tag);
        #1;
        reset = 1'b0; pred_req = 1'b1; upd_valid = 1'b1; tbl_clear = 1'b0;
        #1;
        chk_zero(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; pred_req = 1'b0; upd_valid = 1'b0;
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i < ENTRIES; i++) begin
            idle();
            chk({tag, "_addr"}, tbl_addr, i);
            chk({tag, "_we"}, tbl_we, 1);
            chk({tag, "_not_done"}, init_done, 0);
        end
        idle();
        chk({tag, "_done"}, init_done, 1);
        chk({tag, "_ready"}, upd_ready, 1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [1:0]  uold;
        logic        e_grant;
        logic        e_en;
        logic        e_we;
        logic [5:0]  e_addr;
        logic [1:0]  e_wdata;
        logic        e_pv;
        logic [1:0]  e_ctr;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int gap, writes;
        bit hi_req;

        for (int i = 0; i < ENTRIES; i++) begin pht_mem[i] = 2'b11; ref_pht[i] = 2'b11; end
        tbl_rdata = 2'b00;
        model_reset();

        vecs[0]  = '{1'b1, 32'h10,  1'b0, 32'h0,  1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 6'd4,  2'd0, 1'b0, 2'd0};
        vecs[1]  = '{1'b0, 32'h0,   1'b1, 32'h20, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 1'b1, 2'd1};
        vecs[2]  = '{1'b0, 32'h0,   1'b1, 32'h24, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 6'd8,  2'd3, 1'b0, 2'd0};
        vecs[3]  = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 6'd9,  2'd0, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 32'h20,  1'b0, 32'h0,  1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 6'd8,  2'd0, 1'b0, 2'd0};
        vecs[6]  = '{1'b1, 32'h24,  1'b0, 32'h0,  1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 6'd9,  2'd0, 1'b1, 2'd3};
        vecs[7]  = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 1'b1, 2'd0};
        vecs[8]  = '{1'b1, 32'h100, 1'b1, 32'hFC, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 6'd0,  2'd0, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 32'h104, 1'b1, 32'h8,  1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 6'd1,  2'd0, 1'b1, 2'd1};
        vecs[10] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 6'd63, 2'd2, 1'b1, 2'd1};
        vecs[11] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 6'd2,  2'd1, 1'b0, 2'd0};
        vecs[12] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 1'b0, 2'd0};
        vecs[13] = '{1'b1, 32'hFC,  1'b0, 32'h0,  1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 6'd63, 2'd0, 1'b0, 2'd0};
        vecs[14] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd0, 1'b1, 2'd2};

        // ---------------- reset ----------------
        reset = 1'b0; tbl_clear = 1'b0; pred_req = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_ctr_old = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        pred_req = 1'b1; upd_valid = 1'b1;
        #1;
        chk_zero("por");
        @(posedge clk);
        #1;
        reset = 1'b1; pred_req = 1'b0; upd_valid = 1'b0;

        sweep_check("sweep0");

        // ---------------- directed vectors ----------------
        foreach (vecs[i]) begin
            cycle(vecs[i].req, vecs[i].pc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].uold, 1'b0);
            chk($sformatf("v%0d_grant", i), pred_grant, vecs[i].e_grant);
            chk($sformatf("v%0d_en", i), tbl_en, vecs[i].e_en);
            chk($sformatf("v%0d_we", i), tbl_we, vecs[i].e_we);
            if (vecs[i].e_en) chk($sformatf("v%0d_addr", i), tbl_addr, vecs[i].e_addr);
            if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), tbl_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_pvalid", i), pred_valid, vecs[i].e_pv);
            chk($sformatf("v%0d_pctr", i), pred_ctr, vecs[i].e_ctr);
        end

        // ---------------- starvation: fill queue under constant reads ----------------
        for (int i = 0; i < 4; i++)
            cycle(1'b1, $urandom, 1'b1, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
        cycle(1'b1, $urandom, 1'b1, $urandom, 1'b1, 2'd1, 1'b0);
        chk("full_ready", upd_ready, 0);
        chk("full_grant", pred_grant, 1);
        cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
        chk("starve_write", tbl_we, 1);
        gap = 0; writes = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
            if (tbl_we) begin
                chk("starve_gap", gap, SMAX);
                gap = 0; writes++;
            end else if (pred_grant) gap++;
        end
        chk("starve_writes", writes, 3);

        // ---------------- clear with queued updates, then reset mid-sweep ----------------
        for (int i = 0; i < 3; i++)
            cycle(1'b1, $urandom, 1'b1, $urandom, 1'b1, 2'd2, 1'b0);
        cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 2'd0, 1'b1);
        chk("clear_en", tbl_en, 0);
        chk("clear_pvalid", pred_valid, 1);
        for (int i = 0; i < 20; i++) begin
            idle();
            chk("clr_sweep_addr", tbl_addr, i);
            chk("clr_sweep_wdata", tbl_wdata, 1);
            chk("clr_sweep_ready", upd_ready, 0);
        end
        idle();
        chk("mid_sweep_addr", tbl_addr, 20);
        reset_pulse("midrst");
        sweep_check("sweep1");

        // ---------------- randomized traffic ----------------
        hi_req = 0;
        for (int i = 0; i < 2400; i++) begin
            if (i % 200 == 0) hi_req = ~hi_req;
            cycle(1'($urandom_range(0, 9) < (hi_req ? 9 : 5)), $urandom,
                  1'($urandom_range(0, 9) < 4), $urandom,
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bp_table_ctrl.md
BP_TABLE_CTRL -- requirements
Module: bp_table_ctrl

Interface
REQ-001 Parameter: XLEN, riscv_pkg value (32); instruction/PC width.
REQ-002 Parameter: PHT_ENTRIES, 64; pattern-history-table depth, power of two; IDX_W = log2(PHT_ENTRIES).
REQ-003 Parameter: QDEPTH, 4; update-queue depth, power of two.
REQ-004 Parameter: STARVE_MAX, 4; consecutive update-denied cycles before update priority.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  asynchronous assert, active-low (0 = reset).
REQ-007 tbl_clear  in  1  one-cycle pulse; re-initialise table and drop queue.
REQ-008 pred_req  in  1  IF requests a PHT read this cycle.
REQ-009 pred_pc  in  XLEN  PC to predict.
REQ-010 pred_grant  out  1  combinational; read issued to table this cycle.
REQ-011 pred_valid  out  1  registered; pred_ctr/pred_taken valid.
REQ-012 pred_ctr  out  2  counter read for granted request.
REQ-013 pred_taken  out  1  pred_ctr[1].
REQ-014 upd_valid  in  1  EX resolved a conditional branch.
REQ-015 upd_pc  in  XLEN  branch PC.
REQ-016 upd_taken  in  1  actual outcome.
REQ-017 upd_ctr_old  in  2  counter value delivered with the original prediction.
REQ-018 upd_ready  out  1  queue can accept; update accepted when upd_valid && upd_ready.
REQ-019 tbl_en  out  1  table port enable.
REQ-020 tbl_we  out  1  write enable (with tbl_en).
REQ-021 tbl_addr  out  IDX_W  table index.
REQ-022 tbl_wdata  out  2  write data.
REQ-023 tbl_rdata  in  2  read data, valid the cycle after a read.
REQ-024 init_done  out  1  high in RUN state.

Function
REQ-025 Index for any PC SHALL be pc[IDX_W+1:2].
REQ-026 FSM SHALL have states INIT and RUN; reset and tbl_clear enter INIT.
REQ-027 INIT SHALL write 2'b01 (weakly not-taken) to index 0..PHT_ENTRIES-1, one per cycle, ascending, then enter RUN next cycle; sweep takes exactly PHT_ENTRIES cycles.
REQ-028 In INIT: pred_grant=0, upd_ready=0, queue empty.
REQ-029 tbl_clear in RUN SHALL restart sweep at index 0 next cycle; tbl_clear in INIT SHALL restart sweep at index 0; any in-flight pred_valid for the clear cycle SHALL still assert.
REQ-030 Accepted updates SHALL enqueue {index, new_ctr}, new_ctr = saturating upd_ctr_old+1 if upd_taken else -1 (3 stays 3, 0 stays 0).
REQ-031 upd_ready = RUN && queue not full; no enqueue-while-full even if dequeuing same cycle.
REQ-032 RUN arbitration per cycle: if queue non-empty and (pred_req==0 or starve_cnt==STARVE_MAX) head is written (tbl_en=1, tbl_we=1) and dequeued; else if pred_req, read granted (tbl_en=1, tbl_we=0, pred_grant=1); else tbl_en=0.
REQ-033 starve_cnt SHALL increment each RUN cycle a read wins while queue non-empty, saturate at STARVE_MAX, and clear on any dequeue or when queue empty.
REQ-034 pred_valid SHALL assert exactly one cycle after pred_grant, with pred_ctr=tbl_rdata; otherwise 0.
REQ-035 No forwarding: a read SHALL return table contents even if a queued update targets the same index.
REQ-036 Queue SHALL be FIFO; same-cycle enqueue and dequeue (non-full) SHALL keep count unchanged.

Reset
REQ-037 reset low SHALL immediately force: state=INIT, sweep index=0, queue empty, starve_cnt=0, pred_valid=0, init_done=0.
REQ-038 During reset all outputs SHALL be 0 (tbl_en/tbl_we held 0); sweep writes start the first clk edge after reset deasserts.
REQ-039 Reset mid-sweep or mid-queue SHALL discard all state; no partial writes after assertion.

Verification
REQ-040 Reset release, PHT_ENTRIES=64 -> 64 consecutive writes addr 0..63 data 01, init_done rises cycle 65, upd_ready rises with it.
REQ-041 RUN, pred_req pc=0x0000_0010 -> pred_grant same cycle, tbl_addr=4, next cycle pred_valid=1, pred_ctr=01, pred_taken=0.
REQ-042 Updates ctr_old=3 taken and ctr_old=0 not-taken, pred_req=0 -> writes data 3 then 0 on consecutive cycles.
REQ-043 Queue filled with 4 updates, pred_req held high -> upd_ready=0; 4 reads granted, 5th cycle write of head, starve_cnt clears, repeat until empty.
REQ-044 tbl_clear with 3 queued updates -> queue empties, sweep restarts at 0, no queued write ever issued.
REQ-045 reset asserted at sweep index 20 -> outputs 0 immediately; after release sweep restarts at index 0.
